// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Shared types and constants for the UART receive path.
//            - rx_state_t : receiver FSM states
//            - START_BIT / STOP_BIT / IDLE_LVL : serial line levels
//            - DEF_D_WIDTH : default number of data bits per frame
//  Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        BREAK = 3'd0,
        IDLE  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } rx_state_t;

    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam logic IDLE_LVL    = 1'b1;
    localparam int   DEF_D_WIDTH = 4;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_sync
//  Purpose : Two-flop synchronizer for the asynchronous serial input.
//            Both flops reset to the idle line level so that a reset never
//            looks like a start bit.
//  Ports   : clk  - clock
//            rst  - asynchronous active-low reset
//            i_rx - raw serial line
//            o_rx - serial line synchronized to clk
//  Revision: 1.0 - initial release
// ============================================================================
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_rx
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= IDLE_LVL;
            r_sync <= IDLE_LVL;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rx = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_receive.sv
`default_nettype none
// ============================================================================
//  Module  : uart_receive
//  Purpose : UART serial receiver. Recovers frames of one start bit (0),
//            D_WIDTH data bits LSB first and one stop bit (1) from an idle-high
//            line, and presents each word in a single-entry valid/ready
//            holding register.
//  Ports   : clk      - clock
//            rst      - asynchronous active-low reset
//            rx       - serial line, idle high
//            rx_ready - consumer accepts rx_data this cycle
//            rx_data  - received word, valid while rx_valid is high
//            rx_valid - holding register full
//            rx_busy  - frame in progress (START/DATA/STOP)
//            rx_ferr  - one-cycle pulse: stop bit sampled low
//            rx_ovr   - one-cycle pulse: frame completed while register full
//  Config  : UART_RX_SYNC_EN - when defined, rx passes through a two-flop
//            synchronizer (adds two cycles of latency); otherwise rx must
//            already be synchronous to clk.
//  Revision: 1.0 - initial release
// ============================================================================
module uart_receive
    import uart_pkg::*;
#(
    parameter int D_WIDTH      = DEF_D_WIDTH,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_ferr,
    output logic               rx_ovr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int BIT_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_tick_half = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_bit_last  = BIT_W'(D_WIDTH - 1);

    rx_state_t          r_state;
    logic [CNT_W-1:0]   r_tick;
    logic [BIT_W-1:0]   r_bit_idx;
    logic [D_WIDTH-1:0] r_shift;
    logic [D_WIDTH-1:0] r_data;
    logic               r_valid;
    logic               r_ferr;
    logic               r_ovr;

    logic               w_rx;
    logic [CNT_W-1:0]   w_tick_nxt;
    logic               w_sample;
    logic               w_complete;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .i_rx (rx),
        .o_rx (w_rx)
    );
`else
    assign w_rx = rx;
`endif

    // The tick counter runs freely across state boundaries inside a frame, so
    // the sample of the next bit always lands CLKS_PER_BIT cycles after the
    // previous one, regardless of which state made the previous decision.
    assign w_tick_nxt = (r_tick == c_tick_last) ? '0 : r_tick + 1'b1;
    assign w_sample   = (r_tick == c_tick_half);
    assign w_complete = (r_state == STOP) && w_sample && (w_rx == STOP_BIT);

    // ------------------------------------------------------------------------
    // Frame recovery FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= BREAK;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            unique case (r_state)
                // Hold off until the line has been seen high, so a line that is
                // low out of reset or after a framing error is not a start bit.
                BREAK: begin
                    r_tick <= '0;
                    if (w_rx == IDLE_LVL) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    r_bit_idx <= '0;
                    if (w_rx == START_BIT) begin
                        // This cycle is tick 0 of the start bit.
                        r_tick <= w_tick_nxt;
                        if (HALF == 0) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= START;
                        end
                    end else begin
                        r_tick <= '0;
                    end
                end
                START: begin
                    r_tick <= w_tick_nxt;
                    if (w_sample) begin
                        if (w_rx == START_BIT) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_tick  <= '0;
                        end
                    end
                end
                DATA: begin
                    r_tick <= w_tick_nxt;
                    if (w_sample) begin
                        // LSB arrives first, so shift in from the top.
                        r_shift <= (D_WIDTH'(w_rx) << (D_WIDTH - 1)) | (r_shift >> 1);
                        if (r_bit_idx == c_bit_last) begin
                            r_bit_idx <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    r_tick <= w_tick_nxt;
                    if (w_sample) begin
                        r_tick <= '0;
                        if (w_rx == STOP_BIT) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= BREAK;
                            r_ferr  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= BREAK;
                    r_tick  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Holding register: a completion that coincides with a transfer reloads
    // the register without dropping valid; a completion into a full register
    // that is not being drained is dropped and flagged.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_complete) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;
    assign rx_ovr   = r_ovr;
    assign rx_busy  = (r_state == START) || (r_state == DATA) || (r_state == STOP);

endmodule : uart_receive
`default_nettype wire

// File: tb/tb_uart_receive.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_receive
//  Purpose : Self-checking bench for uart_receive. Two instances: one at the
//            native rate (CLKS_PER_BIT=1) and one oversampled
//            (CLKS_PER_BIT=4). Stimulus pushes expected words into a queue per
//            instance; monitors pop and compare on every valid/ready transfer.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_uart_receive;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif
    localparam int LAT = 6 + SYNC_EXTRA;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx1, ready1, valid1, busy1, ferr1, ovr1;
    logic [3:0] data1;
    logic       rx4, ready4, valid4, busy4, ferr4, ovr4;
    logic [3:0] data4;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [3:0] q1[$];
    logic [3:0] q4[$];
    int ovr_cnt1 = 0, ferr_cnt1 = 0, valid_rise1 = -1, last_start1 = 0;
    int ovr_cnt4 = 0, ferr_cnt4 = 0;

    uart_receive #(.D_WIDTH(4), .CLKS_PER_BIT(1)) dut (
        .clk(clk), .rst(rst), .rx(rx1), .rx_ready(ready1), .rx_data(data1),
        .rx_valid(valid1), .rx_busy(busy1), .rx_ferr(ferr1), .rx_ovr(ovr1)
    );

    uart_receive #(.D_WIDTH(4), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .rx_ready(ready4), .rx_data(data4),
        .rx_valid(valid4), .rx_busy(busy4), .rx_ferr(ferr4), .rx_ovr(ovr4)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the native-rate instance
    initial begin : mon1
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && valid1 && ready1) begin
                if (q1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL word1_unexpected: got 0x%0h, required no transfer (cycle %0d)", data1, cyc);
                end else begin
                    check("word1", int'(data1), int'(q1.pop_front()));
                end
            end
            if (ovr1)  ovr_cnt1++;
            if (ferr1) ferr_cnt1++;
            if (valid1 && !prev_valid) valid_rise1 = cyc;
            prev_valid = valid1;
        end
    end

    // Monitor for the oversampled instance
    initial begin : mon4
        forever begin
            @(negedge clk);
            if (rst && valid4 && ready4) begin
                if (q4.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL word4_unexpected: got 0x%0h, required no transfer (cycle %0d)", data4, cyc);
                end else begin
                    check("word4", int'(data4), int'(q4.pop_front()));
                end
            end
            if (ovr4)  ovr_cnt4++;
            if (ferr4) ferr_cnt4++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // One frame on rx1, one cycle per bit; the line is left at the stop level.
    task automatic send1(input logic [3:0] d, input logic stop);
        logic [5:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 rx1 = bits[i];
            if (i == 0) last_start1 = cyc;
        end
    endtask

    task automatic idle1(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rx1 = 1'b1;
        end
    endtask

    // One frame on rx4, four cycles per bit.
    task automatic send4(input logic [3:0] d, input logic stop);
        logic [5:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 6; i++) begin
            repeat (4) begin
                @(posedge clk);
                #1 rx4 = bits[i];
            end
        end
    endtask

    task automatic idle4(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rx4 = 1'b1;
        end
    endtask

    initial begin : stim
        int   base_ovr, base_ferr;
        logic seen;

        rst = 1'b0; rx1 = 1'b0; rx4 = 1'b1; ready1 = 1'b0; ready4 = 1'b1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs1", int'({data1, valid1, busy1, ferr1, ovr1}), 0);
        check("reset_outs4", int'({data4, valid4, busy4, ferr4, ovr4}), 0);

        // ---- release with line held low: receiver must wait for high ----
        rst  = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | busy1 | valid1;
        end
`ifndef UART_RX_SYNC_EN
        check("break_after_reset", int'(seen), 0);
`endif
        idle1(3);

        // ---- 0xA with rx_ready=1, latency from start bit ----
        ready1 = 1'b1;
        q1.push_back(4'hA);
        send1(4'hA, 1'b1);
        idle1(6);
        check("latency_0xA", valid_rise1 - last_start1, LAT);
        check("valid_dropped_after_xfer", int'(valid1), 0);

        // ---- back-to-back 0x1, 0xE with rx_ready=1 ----
        q1.push_back(4'h1);
        q1.push_back(4'hE);
        send1(4'h1, 1'b1);
        send1(4'hE, 1'b1);
        idle1(6);

        // ---- back-to-back 0x3, 0xC with rx_ready=0: overrun ----
        ready1   = 1'b0;
        base_ovr = ovr_cnt1;
        q1.push_back(4'h3);
        send1(4'h3, 1'b1);
        send1(4'hC, 1'b1);
        idle1(6);
        @(negedge clk);
        check("ovr_pulses", ovr_cnt1 - base_ovr, 1);
        check("held_valid", int'(valid1), 1);
        check("held_data", int'(data1), 4'h3);
        @(posedge clk);
        #1 ready1 = 1'b1;
        idle1(2);
        #1 ready1 = 1'b0;
        idle1(2);

        // ---- transfer coincides with completion: reload, no overrun ----
        base_ovr = ovr_cnt1;
        q1.push_back(4'h3);
        q1.push_back(4'hC);
        fork
            begin
                send1(4'h3, 1'b1);
                send1(4'hC, 1'b1);
            end
            begin
                repeat (12 + SYNC_EXTRA) @(posedge clk);
                #1 ready1 = 1'b1;
                @(posedge clk);
                #1 ready1 = 1'b0;
            end
        join
        idle1(6);
        @(negedge clk);
        check("coincide_no_ovr", ovr_cnt1 - base_ovr, 0);
        check("coincide_valid", int'(valid1), 1);
        check("coincide_data", int'(data1), 4'hC);
        @(posedge clk);
        #1 ready1 = 1'b1;
        idle1(3);

        // ---- 0x5 with stop bit 0: framing error, then BREAK ----
        base_ferr = ferr_cnt1;
        base_ovr  = ovr_cnt1;
        send1(4'h5, 1'b0);
        seen = 1'b0;
        repeat (3 + SYNC_EXTRA) @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            seen = seen | busy1;
        end
        check("ferr_pulses", ferr_cnt1 - base_ferr, 1);
        check("ferr_no_valid", int'(valid1), 0);
        check("ferr_no_ovr", ovr_cnt1 - base_ovr, 0);
        check("break_after_ferr", int'(seen), 0);
        idle1(4);
        q1.push_back(4'h7);
        send1(4'h7, 1'b1);
        idle1(6);

        // ---- oversampled: start glitch rejected, then 0x6 ----
        @(posedge clk);
        #1 rx4 = 1'b0;
        idle4(10);
        @(negedge clk);
        check("glitch_busy4", int'(busy4), 0);
        check("glitch_valid4", int'(valid4), 0);
        q4.push_back(4'h6);
        send4(4'h6, 1'b1);
        idle4(10);
        check("ferr4_none", ferr_cnt4, 0);
        check("ovr4_none", ovr_cnt4, 0);

        // ---- reset in the middle of DATA ----
        ready1 = 1'b0;
        send1(4'h6, 1'b1);
        idle1(4);
        @(posedge clk); #1 rx1 = 1'b0;
        @(posedge clk); #1 rx1 = 1'b1;
        @(posedge clk); #1 rx1 = 1'b0;
        repeat (SYNC_EXTRA) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1 check("midframe_reset_outs", int'({data1, valid1, busy1, ferr1, ovr1}), 0);
        rx1 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle1(3);
        ready1 = 1'b1;
        q1.push_back(4'h9);
        send1(4'h9, 1'b1);
        idle1(8);

        check("queue1_drained", q1.size(), 0);
        check("queue4_drained", q4.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_receive
`default_nettype wire
